// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and execute-side resolution bus of the branch predict unit.
// The unit is the slave; the fetch/execute pipeline logic is the master.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [3:0]      ex_br_type;
  logic [XLEN-1:0] ex_src0;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] br_cnt;
  logic [XLEN-1:0] miss_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_br_type, ex_src0, ex_src1,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, br_cnt, miss_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_br_type, ex_src0, ex_src1,
           ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB predictor (2-bit counters) with EX-stage resolution and redirect.
// Statistics counters br_cnt/miss_cnt are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BTB_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b10
) (
  input  logic                 clk,
  input  logic                 rstn,
  branch_predict_unit_if.slave bus
);
  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [3:0] BR_BEQ  = 4'd0;
  localparam logic [3:0] BR_BNE  = 4'd1;
  localparam logic [3:0] BR_JAL  = 4'd2;
  localparam logic [3:0] BR_JALR = 4'd3;
  localparam logic [3:0] BR_BLT  = 4'd4;
  localparam logic [3:0] BR_BGE  = 4'd5;
  localparam logic [3:0] BR_BLTU = 4'd6;
  localparam logic [3:0] BR_BGEU = 4'd7;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic [BTB_DEPTH-1:0] valid_r;
  logic [BTB_DEPTH-1:0] jump_r;
  logic [TAG_W-1:0]     tag_r    [BTB_DEPTH];
  logic [XLEN-1:0]      target_r [BTB_DEPTH];
  logic [1:0]           cnt_r    [BTB_DEPTH];

  logic [IDX-1:0]   if_idx_s;
  logic [TAG_W-1:0] if_tag_s;
  logic             if_hit_s;
  logic             pred_s;
  logic [XLEN-1:0]  pred_target_s;
  logic [IDX-1:0]   ex_idx_s;
  logic [TAG_W-1:0] ex_tag_s;
  logic             ex_hit_s;
  logic             actual_s;
  logic             is_jump_s;
  logic             is_br_s;
  logic             mispredict_s;
  logic [XLEN-1:0]  redirect_pc_s;
  logic             unused_s;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign if_idx_s  = bus.if_pc[IDX+1:2];
  assign if_tag_s  = bus.if_pc[XLEN-1:IDX+2];
  assign ex_idx_s  = bus.ex_pc[IDX+1:2];
  assign ex_tag_s  = bus.ex_pc[XLEN-1:IDX+2];
  assign ex_hit_s  = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign is_jump_s = (bus.ex_br_type == BR_JAL) || (bus.ex_br_type == BR_JALR);
  assign is_br_s   = ~bus.ex_br_type[3];
  assign unused_s  = ^bus.if_pc[1:0];

  // IF lookup: combinational read of the current table contents
  always_comb begin
    if_hit_s = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    pred_s   = if_hit_s && (jump_r[if_idx_s] || cnt_r[if_idx_s][1]);
    if (pred_s) begin
      pred_target_s = target_r[if_idx_s];
    end else begin
      pred_target_s = '0;
    end
  end

  // EX branch condition evaluation
  always_comb begin
    actual_s = 1'b0;
    case (bus.ex_br_type)
      BR_BEQ:           actual_s = (bus.ex_src0 == bus.ex_src1);
      BR_BNE:           actual_s = (bus.ex_src0 != bus.ex_src1);
      BR_JAL, BR_JALR:  actual_s = 1'b1;
      BR_BLT:           actual_s = ($signed(bus.ex_src0) <  $signed(bus.ex_src1));
      BR_BGE:           actual_s = ($signed(bus.ex_src0) >= $signed(bus.ex_src1));
      BR_BLTU:          actual_s = (bus.ex_src0 <  bus.ex_src1);
      BR_BGEU:          actual_s = (bus.ex_src0 >= bus.ex_src1);
      default:          actual_s = 1'b0;
    endcase
  end

  // Mispredict detection and correct next-PC selection
  always_comb begin
    mispredict_s = bus.ex_valid &&
                   ((actual_s != bus.ex_pred_taken) ||
                    (actual_s && (bus.ex_pred_target != bus.ex_target)));
    if (!bus.ex_valid) begin
      redirect_pc_s = '0;
    end else if (actual_s) begin
      redirect_pc_s = bus.ex_target;
    end else begin
      redirect_pc_s = bus.ex_pc + PC_STEP;
    end
  end

  assign bus.pred_taken  = pred_s;
  assign bus.pred_target = pred_target_s;
  assign bus.redirect    = mispredict_s;
  assign bus.redirect_pc = redirect_pc_s;

  // BTB training from resolved EX instructions; non-branches evict aliasing entries
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= '0;
      jump_r  <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        cnt_r[i]    <= 2'b00;
      end
    end else if (bus.ex_valid) begin
      if (actual_s) begin
        if (ex_hit_s) begin
          cnt_r[ex_idx_s]    <= sat_inc(cnt_r[ex_idx_s]);
          target_r[ex_idx_s] <= bus.ex_target;
        end else begin
          valid_r[ex_idx_s]  <= 1'b1;
          tag_r[ex_idx_s]    <= ex_tag_s;
          target_r[ex_idx_s] <= bus.ex_target;
          jump_r[ex_idx_s]   <= is_jump_s;
          cnt_r[ex_idx_s]    <= is_jump_s ? 2'b11 : CNT_INIT;
        end
      end else if (ex_hit_s) begin
        if (is_br_s) begin
          cnt_r[ex_idx_s] <= sat_dec(cnt_r[ex_idx_s]);
        end else begin
          valid_r[ex_idx_s] <= 1'b0;
        end
      end
    end
  end

`ifdef BPU_STATS_EN
  localparam logic [XLEN-1:0] CNT_ONE = XLEN'(1'b1);

  logic [XLEN-1:0] br_cnt_r;
  logic [XLEN-1:0] miss_cnt_r;

  // Saturating resolved-branch and redirect statistics
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt_r   <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (bus.ex_valid && is_br_s && (br_cnt_r != '1)) begin
        br_cnt_r <= br_cnt_r + CNT_ONE;
      end
      if (mispredict_s && (miss_cnt_r != '1)) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

  assign bus.br_cnt   = br_cnt_r;
  assign bus.miss_cnt = miss_cnt_r;
`else
  assign bus.br_cnt   = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: per-cycle reference model check plus literal pins.
module tb_branch_predict_unit;
  logic clk;
  logic rstn;
  int   total;
  int   bad;

`ifdef BPU_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  branch_predict_unit_if #(.XLEN(32)) bus ();

  branch_predict_unit #(.XLEN(32), .BTB_DEPTH(64), .CNT_INIT(2'b10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int unsigned tag;
    bit [31:0]   tgt;
    bit          jmp;
    int          cnt;
  } ent_t;

  ent_t        m_btb [64];
  int unsigned m_br;
  int unsigned m_miss;

  bit walk_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit walk_p [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_idx(input bit [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned m_tag(input bit [31:0] pc);
    return pc / 256;
  endfunction

  function automatic bit m_taken(input bit [3:0] ty, input bit [31:0] a, input bit [31:0] b);
    case (ty)
      4'd0:       return a == b;
      4'd1:       return a != b;
      4'd2, 4'd3: return 1'b1;
      4'd4:       return $signed(a) <  $signed(b);
      4'd5:       return $signed(a) >= $signed(b);
      4'd6:       return a <  b;
      4'd7:       return a >= b;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference model: check outputs mid-cycle, then advance to the post-edge state
  always @(negedge clk) begin : cmp
    int unsigned ii, ei;
    bit          hit_i, hit_e, act, mis, e_pred;
    bit [31:0]   e_rpc;
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        m_btb[i].v   = 1'b0;
        m_btb[i].tag = 0;
        m_btb[i].tgt = 32'h0;
        m_btb[i].jmp = 1'b0;
        m_btb[i].cnt = 0;
      end
      m_br   = 0;
      m_miss = 0;
      chk("m_rst_pred", bus.pred_taken, 32'h0);
      chk("m_rst_redirect", bus.redirect, 32'h0);
      chk("m_rst_br_cnt", bus.br_cnt, 32'h0);
    end else begin
      ii     = m_idx(bus.if_pc);
      hit_i  = m_btb[ii].v && (m_btb[ii].tag == m_tag(bus.if_pc));
      e_pred = hit_i && (m_btb[ii].jmp || m_btb[ii].cnt >= 2);
      chk("m_pred_taken", bus.pred_taken, e_pred);
      chk("m_pred_target", bus.pred_target, e_pred ? m_btb[ii].tgt : 32'h0);

      ei    = m_idx(bus.ex_pc);
      hit_e = m_btb[ei].v && (m_btb[ei].tag == m_tag(bus.ex_pc));
      act   = m_taken(bus.ex_br_type, bus.ex_src0, bus.ex_src1);
      mis   = bus.ex_valid && ((act != bus.ex_pred_taken) ||
                               (act && (bus.ex_pred_target != bus.ex_target)));
      e_rpc = !bus.ex_valid ? 32'h0 : (act ? bus.ex_target : bus.ex_pc + 32'd4);
      chk("m_redirect", bus.redirect, mis);
      chk("m_redirect_pc", bus.redirect_pc, e_rpc);
      chk("m_br_cnt", bus.br_cnt, STATS_ON * m_br);
      chk("m_miss_cnt", bus.miss_cnt, STATS_ON * m_miss);

      if (bus.ex_valid) begin
        if (act && hit_e) begin
          m_btb[ei].cnt = (m_btb[ei].cnt < 3) ? m_btb[ei].cnt + 1 : 3;
          m_btb[ei].tgt = bus.ex_target;
        end else if (act) begin
          m_btb[ei].v   = 1'b1;
          m_btb[ei].tag = m_tag(bus.ex_pc);
          m_btb[ei].tgt = bus.ex_target;
          m_btb[ei].jmp = (bus.ex_br_type == 4'd2) || (bus.ex_br_type == 4'd3);
          m_btb[ei].cnt = m_btb[ei].jmp ? 3 : 2;
        end else if (hit_e && bus.ex_br_type <= 4'd7) begin
          m_btb[ei].cnt = (m_btb[ei].cnt > 0) ? m_btb[ei].cnt - 1 : 0;
        end else if (hit_e) begin
          m_btb[ei].v = 1'b0;
        end
        if (bus.ex_br_type <= 4'd7) m_br++;
        if (mis) m_miss++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_op(input logic [31:0] ipc, input logic v, input logic [3:0] ty,
                       input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    bus.if_pc          = ipc;
    bus.ex_valid       = v;
    bus.ex_br_type     = ty;
    bus.ex_pc          = pc;
    bus.ex_src0        = s0;
    bus.ex_src1        = s1;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptg;
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    ex_op(ipc, 1'b0, 4'd15, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    idle(32'h100);
    chk("rst_pred", bus.pred_taken, 32'h0);
    chk("rst_redirect", bus.redirect, 32'h0);
    tick();
    tick();
    rstn = 1'b1;

    idle(32'h100);
    chk("cold_pred", bus.pred_taken, 32'h0);
    tick();
    ex_op(32'h100, 1'b1, 4'd0, 32'h100, 32'd5, 32'd5, 32'h140, 1'b0, 32'h0);
    chk("beq_redirect", bus.redirect, 32'h1);
    chk("beq_rpc", bus.redirect_pc, 32'h140);
    chk("beq_same_cycle_pred", bus.pred_taken, 32'h0);
    tick();
    idle(32'h100);
    chk("beq_learned_pred", bus.pred_taken, 32'h1);
    chk("beq_learned_tgt", bus.pred_target, 32'h140);
    tick();

    // counter walk: nt x3 from 2, taken x4 to saturation, then one nt stays predicted
    for (int i = 0; i < 8; i++) begin
      ex_op(32'h100, 1'b1, 4'd0, 32'h100, 32'd5, walk_t[i] ? 32'd5 : 32'd6, 32'h140,
            walk_p[i], walk_p[i] ? 32'h140 : 32'h0);
      chk($sformatf("walk_pred%0d", i), bus.pred_taken, walk_p[i]);
      chk($sformatf("walk_redir%0d", i), bus.redirect, walk_t[i] != walk_p[i]);
      chk($sformatf("walk_rpc%0d", i), bus.redirect_pc, walk_t[i] ? 32'h140 : 32'h104);
      tick();
    end
    idle(32'h100);
    chk("walk_sat_pred", bus.pred_taken, 32'h1);
    tick();

    ex_op(32'h180, 1'b1, 4'd4, 32'h180, 32'hFFFF_FFFF, 32'd1, 32'h1C0, 1'b0, 32'h0);
    chk("blt_redirect", bus.redirect, 32'h1);
    chk("blt_rpc", bus.redirect_pc, 32'h1C0);
    tick();
    ex_op(32'h184, 1'b1, 4'd6, 32'h184, 32'hFFFF_FFFF, 32'd1, 32'h1C4, 1'b1, 32'h1C4);
    chk("bltu_redirect", bus.redirect, 32'h1);
    chk("bltu_rpc", bus.redirect_pc, 32'h188);
    tick();
    ex_op(32'h188, 1'b1, 4'd5, 32'h188, 32'hFFFF_FFFF, 32'd1, 32'h1C8, 1'b0, 32'h0);
    chk("bge_redirect", bus.redirect, 32'h0);
    chk("bge_rpc", bus.redirect_pc, 32'h18C);
    tick();
    ex_op(32'h18C, 1'b1, 4'd7, 32'h18C, 32'hFFFF_FFFF, 32'd1, 32'h1D0, 1'b0, 32'h0);
    chk("bgeu_redirect", bus.redirect, 32'h1);
    chk("bgeu_rpc", bus.redirect_pc, 32'h1D0);
    tick();
    ex_op(32'h190, 1'b1, 4'd1, 32'h190, 32'd3, 32'd4, 32'h1E0, 1'b1, 32'h1E0);
    chk("bne_redirect", bus.redirect, 32'h0);
    chk("bne_rpc", bus.redirect_pc, 32'h1E0);
    tick();
    idle(32'h180);
    chk("blt_learned_tgt", bus.pred_target, 32'h1C0);
    tick();
    idle(32'h184);
    chk("bltu_not_alloc", bus.pred_taken, 32'h0);
    tick();

    ex_op(32'h200, 1'b1, 4'd3, 32'h200, 32'h0, 32'h0, 32'h300, 1'b0, 32'h0);
    chk("jalr_first_rpc", bus.redirect_pc, 32'h300);
    tick();
    idle(32'h200);
    chk("jalr_pred_tgt", bus.pred_target, 32'h300);
    tick();
    ex_op(32'h200, 1'b1, 4'd3, 32'h200, 32'h0, 32'h0, 32'h304, 1'b1, 32'h300);
    chk("jalr_tgt_redirect", bus.redirect, 32'h1);
    chk("jalr_tgt_rpc", bus.redirect_pc, 32'h304);
    chk("jalr_rbw_tgt", bus.pred_target, 32'h300);
    tick();
    idle(32'h200);
    chk("jalr_new_tgt", bus.pred_target, 32'h304);
    tick();

    idle(32'h100);
    chk("alias_tag_miss", bus.pred_taken, 32'h0);
    tick();
    ex_op(32'h200, 1'b1, 4'd8, 32'h200, 32'h0, 32'h0, 32'h0, 1'b1, 32'h304);
    chk("nonbr_redirect", bus.redirect, 32'h1);
    chk("nonbr_rpc", bus.redirect_pc, 32'h204);
    tick();
    idle(32'h200);
    chk("nonbr_evicted", bus.pred_taken, 32'h0);
    tick();
    ex_op(32'h100, 1'b1, 4'd8, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("nonbr_miss_redirect", bus.redirect, 32'h0);
    tick();

    ex_op(32'h240, 1'b1, 4'd2, 32'h240, 32'h0, 32'h0, 32'h400, 1'b1, 32'h400);
    chk("jal_redirect", bus.redirect, 32'h0);
    chk("jal_rpc", bus.redirect_pc, 32'h400);
    tick();
    idle(32'h240);
    chk("jal_pred", bus.pred_taken, 32'h1);
    tick();
    ex_op(32'h240, 1'b0, 4'd0, 32'h300, 32'd5, 32'd5, 32'h140, 1'b1, 32'h999);
    chk("bubble_redirect", bus.redirect, 32'h0);
    chk("bubble_rpc", bus.redirect_pc, 32'h0);
    tick();

    rstn = 1'b0;
    #1;
    chk("async_rst_br", bus.br_cnt, 32'h0);
    chk("async_rst_miss", bus.miss_cnt, 32'h0);
    chk("async_rst_pred", bus.pred_taken, 32'h0);
    tick();
    rstn = 1'b1;
    idle(32'h240);
    chk("post_rst_pred", bus.pred_taken, 32'h0);
    tick();

    for (int i = 0; i < 10; i++) begin
      ex_op(32'h0, 1'b1, 4'd0, 32'h500 + 32'(i * 4), 32'd7, 32'd7, 32'h600,
            i >= 3, (i >= 3) ? 32'h600 : 32'h0);
      tick();
    end
    idle(32'h0);
    chk("stats_br", bus.br_cnt, 32'(STATS_ON * 10));
    chk("stats_miss", bus.miss_cnt, 32'(STATS_ON * 3));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch comparator. Resolves all eight branch/jump types in EX and, unlike the comparator, predicts them in IF. The prediction comes from a direct-mapped branch target buffer with 2-bit saturating counters. EX-stage resolution compares the outcome against the prediction carried down the pipeline and raises a redirect on mispredict. The unit sits between the IF PC mux and the EX stage of the pipelined CPU.

## Interface
- XLEN, 32, data/address width
- BTB_DEPTH, 64, BTB entries; power of two, ≥2; IDX = log2(BTB_DEPTH)
- CNT_INIT, 2'b10, counter value written on allocation of a conditional branch
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- if_pc  in  XLEN  PC being fetched
- pred_taken  out  1  IF prediction: redirect fetch to pred_target
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0
- ex_valid  in  1  EX holds a real (non-bubble, non-flushed) instruction
- ex_pc  in  XLEN  PC of EX instruction
- ex_br_type  in  4  0 beq, 1 bne, 2 jal, 3 jalr, 4 blt, 5 bge, 6 bltu, 7 bgeu, 8–15 not a branch
- ex_src0, ex_src1  in  XLEN  compare operands
- ex_target  in  XLEN  computed target (jalr already masked)
- ex_pred_taken  in  1  pred_taken value carried with this instruction
- ex_pred_target  in  XLEN  pred_target value carried with this instruction
- redirect  out  1  mispredict: flush IF/ID, load redirect_pc
- redirect_pc  out  XLEN  correct next PC
- br_cnt  out  XLEN  resolved branches/jumps (stats)
- miss_cnt  out  XLEN  redirects issued (stats)

## Operation
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. Each entry holds valid, tag, target, is_jump, cnt[1:0].
- IF lookup is combinational: hit = valid && tag match; pred_taken = hit && (is_jump || cnt[1]).
- EX resolution (combinational): beq/bne use equality; blt/bge use signed compare; bltu/bgeu use unsigned compare; jal/jalr are always taken; types 8–15 are not taken.
- A mispredict occurs when ex_valid is high and either:
  - actual ≠ ex_pred_taken, or
  - actual taken and ex_pred_target ≠ ex_target.
- redirect_pc = actual ? ex_target : ex_pc+4. redirect=0 and redirect_pc=0 when ex_valid=0.
- Table update happens at the clock edge when ex_valid is high:
  - Taken and hit: cnt saturating +1 (max 3); target ← ex_target.
  - Taken and miss: allocate. Set valid=1, tag, target, is_jump = (type 2/3), cnt = is_jump ? 2'b11 : CNT_INIT. Any previous occupant is overwritten.
  - Not-taken branch (0,1,4–7) and hit: cnt saturating −1 (min 0). Not-taken and miss: no change.
  - Type 8–15 and hit: valid ← 0, which removes the aliasing entry.

## Timing
- Reset (rstn low, asynchronous): all valid bits, tags, targets, counters, br_cnt and miss_cnt clear to 0. pred_taken=0, redirect=0.
- Prediction and redirect have zero latency. A table update becomes visible to if_pc lookups on the cycle after the edge.
- If IF and EX touch the same index in the same cycle, IF sees the old entry (read-before-write).
- Reset deasserting mid-program: the first cycle after release predicts not-taken for every PC.
- Counters saturate at both ends. No wrap from 3→0 or 0→3.

## Configuration
- BPU_STATS_EN defined:
  - br_cnt increments on each edge where ex_valid is high and type ≤ 7.
  - miss_cnt increments on each edge where redirect=1.
  - Both saturate at all-ones.
- BPU_STATS_EN undefined: the counters are not built; br_cnt and miss_cnt are tied to 0. Prediction behaviour is identical.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0. Resolve beq at 0x100 with src0=src1=5, target 0x140, ex_pred_taken=0 → redirect=1, redirect_pc=0x140. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x140.
- blt with src0=0xFFFFFFFF, src1=1 → taken. bltu with the same operands → not taken; if predicted taken, redirect_pc=ex_pc+4.
- Counter walk on one conditional branch: not-taken ×3 from cnt=2 → pred_taken goes 1,0,0 and cnt holds at 0. Taken ×4 → cnt saturates at 3.
- jalr at 0x200 predicted to 0x300, actual ex_target 0x304 → redirect=1, redirect_pc=0x304. Entry target updates to 0x304.
- Alias (BTB_DEPTH=64): ex_pc=0x100 and ex_pc=0x200 map to the same index. Resolving a type 8 instruction with a tag hit and ex_pred_taken=1 → redirect to ex_pc+4 and the entry is invalidated.
- With BPU_STATS_EN: 10 branches including 3 mispredicts → br_cnt=10, miss_cnt=3. Assert rstn mid-run → both counters read 0 immediately.
